// File: rtl/pipeline_hazard_ctrl.sv
// Sequencing and hazard controller for an NSTAGE in-order pipeline: stage advance,
// bubbles, branch flush, forwarding selects, imem/dmem requests and halt retirement.
module pipeline_hazard_ctrl #(
    parameter int unsigned  NSTAGE    = 5,
    parameter int unsigned  MEM_STAGE = 3,
    parameter int unsigned  REG_AW    = 5,
    parameter int unsigned  FWD       = 1,
    localparam int unsigned SW        = $clog2(NSTAGE)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_wsel,
    input  logic              id_regwr,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_halt,
    input  logic              ex_branch_taken,
    output logic [NSTAGE-1:0] stage_valid,
    output logic [NSTAGE-1:0] adv,
    output logic [NSTAGE-1:0] bubble,
    output logic              imemREN,
    output logic              dmemREN,
    output logic              dmemWEN,
    output logic [SW-1:0]     fwd_rs_sel,
    output logic [SW-1:0]     fwd_rt_sel,
    output logic              halt
);

    localparam int unsigned LAST = NSTAGE - 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALTED
    } run_state_e;

    run_state_e state, state_nxt;

    // Per-stage tracking; stage 1 decode flags come straight from the id_* inputs
    logic [LAST:1]      v_q;
    logic [LAST:2]      regwr_q;
    logic [LAST:2]      hlt_q;
    logic [MEM_STAGE:2] memread_q;
    logic [MEM_STAGE:2] memwrite_q;
    logic [REG_AW-1:0]  wsel_q [2:LAST];
    logic [REG_AW-1:0]  ex_rs_q;
    logic [REG_AW-1:0]  ex_rt_q;

    logic mem_stall, flush, load_use, fetch_stall;
    logic lu_fwd, lu_nofwd, load_wait, retire, halt_leaves_id;

    function automatic logic src_hit(
        input logic              use_rs,
        input logic [REG_AW-1:0] rs,
        input logic              use_rt,
        input logic [REG_AW-1:0] rt,
        input logic [REG_AW-1:0] w
    );
        return (use_rs && (rs != '0) && (rs == w)) || (use_rt && (rt != '0) && (rt == w));
    endfunction

    // Hazard detection and stall priority
    always_comb begin
        mem_stall = v_q[MEM_STAGE] && (memread_q[MEM_STAGE] || memwrite_q[MEM_STAGE]) && !dhit;
        flush     = ex_branch_taken && v_q[2];

        lu_fwd = 1'b0;
        for (int s = 2; s < int'(MEM_STAGE); s++) begin
            if (v_q[s] && memread_q[s] && src_hit(id_use_rs, id_rs, id_use_rt, id_rt, wsel_q[s]))
                lu_fwd = 1'b1;
        end
        lu_nofwd = 1'b0;
        for (int s = 2; s < int'(LAST); s++) begin
            if (v_q[s] && regwr_q[s] && src_hit(id_use_rs, id_rs, id_use_rt, id_rt, wsel_q[s]))
                lu_nofwd = 1'b1;
        end
        load_use    = v_q[1] && ((FWD != 0) ? lu_fwd : lu_nofwd);
        fetch_stall = !ihit || (state != ST_RUN);

        adv    = '0;
        bubble = '0;
        if (nRST || mem_stall) begin
            adv = '0;
        end else if (flush) begin
            adv       = '1;
            bubble[1] = 1'b1;
            bubble[2] = 1'b1;
        end else if (load_use) begin
            adv       = '1;
            adv[1:0]  = 2'b00;
            bubble[2] = 1'b1;
        end else if (fetch_stall) begin
            adv       = '1;
            adv[0]    = 1'b0;
            bubble[1] = 1'b1;
        end else begin
            adv = '1;
        end
    end

    // Forwarding: the youngest (lowest-index) qualifying producer wins
    always_comb begin
        load_wait  = v_q[MEM_STAGE] && memread_q[MEM_STAGE] && !dhit;
        fwd_rs_sel = '0;
        fwd_rt_sel = '0;
        if ((FWD != 0) && !nRST) begin
            for (int s = int'(LAST); s >= 3; s--) begin
                if (v_q[s] && regwr_q[s] && !((s == int'(MEM_STAGE)) && load_wait)) begin
                    if ((ex_rs_q != '0) && (wsel_q[s] == ex_rs_q)) fwd_rs_sel = SW'(s);
                    if ((ex_rt_q != '0) && (wsel_q[s] == ex_rt_q)) fwd_rt_sel = SW'(s);
                end
            end
        end
    end

    assign stage_valid = {v_q, 1'b0};
    assign dmemREN     = v_q[MEM_STAGE] && memread_q[MEM_STAGE];
    assign dmemWEN     = v_q[MEM_STAGE] && memwrite_q[MEM_STAGE] && !memread_q[MEM_STAGE];
    assign imemREN     = (state == ST_RUN);
    assign halt        = (state == ST_HALTED);

    assign retire         = v_q[LAST] && hlt_q[LAST];
    assign halt_leaves_id = v_q[1] && id_halt && adv[2] && !bubble[2];

    // Run/drain/halted sequencing
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_RUN: begin
                if (retire)              state_nxt = ST_HALTED;
                else if (halt_leaves_id) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (retire) state_nxt = ST_HALTED;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (nRST) state <= ST_RUN;
        else      state <= state_nxt;
    end

    // Stage shift: entry i-1 moves to i on adv[i]; a bubble clears the valid bit
    always_ff @(posedge CLK) begin
        if (nRST) begin
            v_q        <= '0;
            regwr_q    <= '0;
            hlt_q      <= '0;
            memread_q  <= '0;
            memwrite_q <= '0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            for (int i = 2; i <= int'(LAST); i++) wsel_q[i] <= '0;
        end else begin
            if (adv[1]) v_q[1] <= !bubble[1];
            for (int i = 2; i <= int'(LAST); i++) begin
                if (adv[i]) v_q[i] <= v_q[i-1] && !bubble[i];
            end
            if (adv[2]) begin
                regwr_q[2]    <= id_regwr;
                hlt_q[2]      <= id_halt;
                memread_q[2]  <= id_memread;
                memwrite_q[2] <= id_memwrite;
                wsel_q[2]     <= id_wsel;
                ex_rs_q       <= (v_q[1] && !bubble[2]) ? id_rs : '0;
                ex_rt_q       <= (v_q[1] && !bubble[2]) ? id_rt : '0;
            end
            for (int i = 3; i <= int'(LAST); i++) begin
                if (adv[i]) begin
                    regwr_q[i] <= regwr_q[i-1];
                    hlt_q[i]   <= hlt_q[i-1];
                    wsel_q[i]  <= wsel_q[i-1];
                end
            end
            for (int i = 3; i <= int'(MEM_STAGE); i++) begin
                if (adv[i]) begin
                    memread_q[i]  <= memread_q[i-1];
                    memwrite_q[i] <= memwrite_q[i-1];
                end
            end
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised sequencing/hazard controller that replaces the single-cycle request unit in the pipelined datapath.
- Tracks per-stage valid/destination state for an NSTAGE in-order pipeline and issues stage advance enables, bubbles, flushes and forwarding selects.
- Owns the imem/dmem request handshakes toward the cache interface and halt retirement.
- Register file, ALU and pipeline data latches stay outside; this block drives only their control.

Parameters:
NSTAGE, 5, pipeline depth; stage 0=IF, 1=ID, 2=EX, NSTAGE-1=WB; legal 4..8
MEM_STAGE, 3, stage index performing data memory access; 2 < MEM_STAGE < NSTAGE-1 (4-stage config uses EX as MEM, MEM_STAGE=2 allowed only when NSTAGE=4)
REG_AW, 5, register address width
FWD, 1, 1=forwarding enabled, 0=stall on every RAW hazard
SW, $clog2(NSTAGE), stage-select width (derived)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous reset, active-high (1 = reset)
ihit  in  1  instruction fetch complete this cycle
dhit  in  1  data access complete this cycle
id_rs, id_rt  in  REG_AW  source regs of instruction in ID
id_use_rs, id_use_rt  in  1  ID instruction reads rs/rt
id_wsel  in  REG_AW  ID destination reg
id_regwr, id_memread, id_memwrite, id_halt  in  1  ID decode flags
ex_branch_taken  in  1  EX resolved taken branch/jump
stage_valid  out  NSTAGE  valid bit per stage
adv  out  NSTAGE  adv[0]=pcEN; adv[i] (i>=1) loads latch feeding stage i
bubble  out  NSTAGE  bubble[i]=1: latch feeding stage i loads a NOP (valid=0)
imemREN  out  1  instruction read request
dmemREN, dmemWEN  out  1  data read/write request
fwd_rs_sel, fwd_rt_sel  out  SW  producing stage for EX operand; 0 = register file
halt  out  1  sticky, set when halt instruction retires from WB

Behaviour:
- State: per-stage valid, regwr, memread, memwrite, halt, wsel for stages 1..NSTAGE-1; rs/rt captured into EX. Entries shift from stage i-1 to i when adv[i].
- Reset (nRST=1 at an edge): all valid=0, halt=0, fetch_stop=0. Combinational outputs then evaluate to:
  - adv=0, bubble=0, fwd_*=0
  - dmemREN=dmemWEN=0
  - imemREN=1
  - Mid-operation reset discards all in-flight state in one cycle.
- Stall priority, highest first:
  1. **mem_stall**
     - Condition: stage MEM_STAGE valid with memread|memwrite and !dhit.
     - adv=0 for all stages; nothing moves.
  2. **flush**
     - Condition: ex_branch_taken and stage 2 valid.
     - adv[0]=1 (PC loads target); bubble[1]=bubble[2]=1.
     - Stages 0..1 contents invalidated; stages >=2 advance normally.
     - Flush overrides load-use and fetch stalls in the same cycle.
  3. **load_use**
     - FWD=1: an ID source (used, nonzero) matches a valid memread producer in stages 2..MEM_STAGE-1.
     - FWD=0: an ID source (used, nonzero) matches any valid regwr producer in stages 2..NSTAGE-2. WB writes first, so stage NSTAGE-1 never stalls.
     - adv[0]=adv[1]=0; bubble[2]=1; stages >=2 advance.
  4. **fetch_stall**
     - Condition: !ihit.
     - adv[0]=0; bubble[1]=1; stages >=2 advance.
  - No stall: adv all 1, bubble 0.
- Register 0 never causes a hazard or forwarding.
- Forwarding (FWD=1):
  - fwd_rs_sel = lowest stage index s in 3..NSTAGE-1 with valid, regwr, wsel==EX rs, rs!=0; else 0. fwd_rt_sel follows the same rule.
  - A load in stage MEM_STAGE is eligible as a producer only once dhit is seen. It cannot reach EX before then because of the freeze.
  - FWD=0: fwd_*=0 constantly.
- Memory handshake:
  - dmemREN=valid&memread at MEM_STAGE; dmemWEN=valid&memwrite at MEM_STAGE.
  - Held until dhit; deasserted the cycle after dhit as the instruction advances.
  - Never both high, since decode guarantees exclusivity. If both flags are set, read wins and WEN=0.
- Halt:
  - When a valid halt instruction advances out of ID, fetch_stop=1.
  - From then: imemREN=0, adv[0]=0, bubble[1]=1.
  - A flush occurring before the halt leaves ID cancels it (fetch_stop not set).
  - When halt is valid in stage NSTAGE-1, halt=1 on the next edge and stays 1 until reset.
  - Older instructions always complete their memory ops before halt asserts.
- imemREN=!fetch_stop & !halt.

Test Plan:
1. Reset held 2 cycles with ihit=1 -> stage_valid=0, dmemREN=dmemWEN=0, halt=0; first cycle after release adv=5'b11111, imemREN=1.
2. Load-use, FWD=1, NSTAGE=5: lw r3 in EX, ID uses rs=3 -> adv[1:0]=0 and bubble[2]=1 for exactly 1 cycle. Next cycle fwd_rs_sel=3 on dhit, then fwd_rs_sel=4 one cycle later if still needed. Same stimulus with FWD=0 -> 2 stall cycles.
3. Dmem wait: sw in stage 3, dhit low 4 cycles -> dmemWEN=1 for 4 cycles, adv=0 throughout. dhit on cycle 5 -> adv all 1, dmemWEN=0 next cycle.
4. Taken branch in EX coincident with !ihit and a load-use match -> adv[0]=1, bubble[2:1]=2'b11. Following cycle stage_valid[2:1]=0.
5. Fetch stall: ihit low 3 cycles with older add in EX -> add reaches WB normally; 3 bubbles visible in stage_valid.
6. Halt after lw: lw, halt fetched back to back -> imemREN=0 once halt leaves ID. halt=1 one cycle after halt occupies WB, and only after lw's dhit. Stays 1 for 10 more cycles; reset clears it.
